dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 128, meaning number of 32-bit data words stored.
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request accept edge to resp_valid high; legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1 bit: memory-stage load/store request present.
REQ-006 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port req_addr, input, 32 bits: byte address; word index = req_addr[31:2].
REQ-008 SHALL have port req_wdata, input, 32 bits: store data.
REQ-009 SHALL have port req_ready, output, 1 bit: request accepted on a rising edge where req_valid and req_ready are both 1.
REQ-010 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, 32 bits: load data, valid while resp_valid = 1.
REQ-012 SHALL have port resp_err, output, 1 bit: access error flag, valid while resp_valid = 1.
REQ-013 SHALL have port stall, output, 1 bit: pipeline hold request.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 SHALL drive req_ready = 1 only in IDLE; requests presented in WAIT or RESP are not accepted, and the requester holds them.
REQ-016 SHALL latch req_write, req_addr and req_wdata on the accept edge; inputs may change after accept.
REQ-017 On accept, SHALL go to RESP when LATENCY = 1; otherwise SHALL go to WAIT with a counter loaded to LATENCY-2.
REQ-018 In WAIT, SHALL decrement the counter each cycle and go to RESP on the edge where the counter is 0.
REQ-019 SHALL perform the access on the edge entering RESP: a store commits to the array and a load captures the array word.
REQ-020 In RESP, SHALL drive resp_valid = 1 for exactly one cycle, then return to IDLE.
REQ-021 SHALL have a throughput of one request per LATENCY+1 cycles under continuous req_valid.
REQ-022 SHALL drive resp_rdata = 0 for stores and whenever resp_valid = 0.
REQ-023 SHALL drive stall = 1 in WAIT and in IDLE while req_valid = 1, and stall = 0 in RESP.
REQ-024 SHALL make a store visible to the next accepted load to the same address, with no stale read.
REQ-025 SHALL initialize array word i to value i at time zero; the array is not reset.

Reset
REQ-026 Asserting rst = 0 SHALL asynchronously force state IDLE, counter 0, and resp_valid, resp_err, resp_rdata and stall to 0.
REQ-027 While rst = 0, req_ready SHALL be 0; it becomes 1 in the first cycle after release.
REQ-028 Reset asserted in WAIT SHALL discard the pending request; a pending store SHALL NOT commit.

Configuration
REQ-029 Macro DMEM_RESPONDER_ERR_EN SHALL control address checking.
REQ-030 With DMEM_RESPONDER_ERR_EN defined, the block SHALL check each request for req_addr[1:0] != 0 or word index >= DEPTH.
REQ-031 For an address that fails the REQ-030 check, the block SHALL drive resp_err = 1 and resp_rdata = 0, perform no store, and keep the same latency.
REQ-032 Without DMEM_RESPONDER_ERR_EN, the block SHALL ignore req_addr[1:0], SHALL take word index = req_addr[31:2] modulo DEPTH, and SHALL tie resp_err to 0.

Verification
REQ-033 Reset, LATENCY=2, load at 0x10 -> req_ready falls after accept, resp_valid high 2 cycles after the accept edge, resp_rdata = 0x00000004, stall low only in the RESP cycle.
REQ-034 Store 0x20 <- 0xDEADBEEF, then load 0x20 -> resp_rdata = 0xDEADBEEF; the store response carries resp_rdata = 0.
REQ-035 Load at 0x13 -> with macro defined: resp_err = 1, resp_rdata = 0; without the macro: resp_err = 0, resp_rdata = 0x00000004.
REQ-036 Store at 0x200 <- 0x1234 -> with macro defined: resp_err = 1 and a later load of word 0 returns 0; without the macro: word 0 becomes 0x1234.
REQ-037 Store 0x08 <- 0x55, rst pulsed low during WAIT -> all outputs 0 immediately; after release, load 0x08 returns 0x00000002.
REQ-038 LATENCY=1 and LATENCY=3 with req_valid held high for 4 loads -> accepts spaced 2 and 4 cycles apart respectively; exactly 4 resp_valid pulses with correct data.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory responder for a pipelined core's
// memory stage. Accepts one load/store at a time, completes it LATENCY cycles
// later with a one-cycle resp_valid pulse, and asks the pipeline to hold
// (stall) while a request is outstanding.
//
// Parameters
//   DEPTH   number of 32-bit words stored
//   LATENCY cycles from accept edge to resp_valid (1..15)
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   req_valid   request present
//   req_write   1 = store, 0 = load
//   req_addr    byte address, word index = req_addr[31:2]
//   req_wdata   store data
//   req_ready   high only in IDLE (and out of reset)
//   resp_valid  one-cycle completion pulse
//   resp_rdata  load data while resp_valid, otherwise 0
//   resp_err    access error flag while resp_valid
//   stall       pipeline hold request
//
// Optional feature: define DMEM_RESPONDER_ERR_EN to flag misaligned or
// out-of-range addresses (no store, zero read data, same latency). Without
// it the low address bits are ignored and the word index wraps modulo DEPTH.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for a request; stall follows req_valid
// ST_WAIT  | request latched, cnt_q counting down to the access edge
// ST_RESP  | access done on entry; resp_valid high for this one cycle

module dmem_responder #(
   parameter int DEPTH   = 128,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        stall
);

   localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
   localparam logic [3:0]  CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
   localparam bit          DIRECT   = (LATENCY == 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef logic [31:0] mem_t [DEPTH];

   function automatic mem_t mem_init();
      mem_t m;
      for (int i = 0; i < DEPTH; i++) begin
         m[i] = 32'(i);
      end
      return m;
   endfunction

   state_t          state_q;
   logic [3:0]      cnt_q;
   logic            write_q;
   logic            err_q;
   logic [AW-1:0]   idx_q;
   logic [31:0]     wdata_q;
   logic            resp_valid_q;
   logic            resp_err_q;
   logic [31:0]     resp_rdata_q;

   // Storage has no reset; contents start as word i = i.
   mem_t            mem_q = mem_init();

   logic            req_err;
   logic [AW-1:0]   req_idx;

`ifdef DMEM_RESPONDER_ERR_EN
   assign req_err = (req_addr[1:0] != 2'b00) ||
                    ({2'b00, req_addr[31:2]} >= DEPTH_W);
   // Only meaningful when req_err is clear, i.e. the index is in range.
   assign req_idx = req_addr[AW+1:2];
`else
   logic [31:0]     word_mod;
   logic            unused_addr;
   assign word_mod    = {2'b00, req_addr[31:2]} % DEPTH_W;
   assign req_idx     = word_mod[AW-1:0];
   assign req_err     = 1'b0;
   assign unused_addr = ^{req_addr[1:0], word_mod[31:AW]};
`endif

   logic            accept;
   logic            from_req;
   logic            enter_resp;
   logic            acc_write;
   logic            acc_err;
   logic [AW-1:0]   acc_idx;
   logic [31:0]     acc_wdata;
   logic [31:0]     load_data;
   logic            mem_we;

   assign req_ready = rst && (state_q == ST_IDLE);
   assign accept    = req_valid && req_ready;

   // With LATENCY = 1 the access happens on the accept edge itself, so the
   // live request fields are used; otherwise the latched copy is used.
   assign from_req   = (state_q == ST_IDLE);
   assign enter_resp = (accept && DIRECT) ||
                       ((state_q == ST_WAIT) && (cnt_q == 4'd0));
   assign acc_write  = from_req ? req_write : write_q;
   assign acc_err    = from_req ? req_err   : err_q;
   assign acc_idx    = from_req ? req_idx   : idx_q;
   assign acc_wdata  = from_req ? req_wdata : wdata_q;

   assign load_data  = (acc_write || acc_err) ? 32'd0 : mem_q[acc_idx];
   assign mem_we     = enter_resp && acc_write && !acc_err;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[acc_idx] <= acc_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 4'd0;
         write_q      <= 1'b0;
         err_q        <= 1'b0;
         idx_q        <= '0;
         wdata_q      <= 32'd0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  write_q <= req_write;
                  err_q   <= req_err;
                  idx_q   <= req_idx;
                  wdata_q <= req_wdata;
                  if (DIRECT) begin
                     state_q      <= ST_RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= acc_err;
                     resp_rdata_q <= load_data;
                  end else begin
                     state_q <= ST_WAIT;
                     cnt_q   <= CNT_LOAD;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q      <= ST_RESP;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= acc_err;
                  resp_rdata_q <= load_data;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_RESP: begin
               state_q      <= ST_IDLE;
               resp_valid_q <= 1'b0;
               resp_err_q   <= 1'b0;
               resp_rdata_q <= 32'd0;
            end
            default: begin
               state_q      <= ST_IDLE;
               resp_valid_q <= 1'b0;
               resp_err_q   <= 1'b0;
               resp_rdata_q <= 32'd0;
            end
         endcase
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign stall      = rst && ((state_q == ST_WAIT) ||
                               ((state_q == ST_IDLE) && req_valid));

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances with LATENCY 1, 2 and 3 share
// clock and reset. A transaction-level model predicts every output each cycle;
// directed transactions add literal expectations.

module tb_dmem_responder;

   localparam int DEPTH = 128;
   localparam int N     = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid  [N];
   logic        req_write  [N];
   logic [31:0] req_addr   [N];
   logic [31:0] req_wdata  [N];
   logic        req_ready  [N];
   logic        resp_valid [N];
   logic [31:0] resp_rdata [N];
   logic        resp_err   [N];
   logic        stall      [N];

   always #5 clk = ~clk;

   generate
      for (genvar g = 0; g < N; g++) begin : g_dut
         dmem_responder #(.DEPTH(DEPTH), .LATENCY(g + 1)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid[g]),
            .req_write  (req_write[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .req_ready  (req_ready[g]),
            .resp_valid (resp_valid[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g]),
            .stall      (stall[g])
         );
      end
   endgenerate

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: got=timeout want=event", name);
   endtask

   // ---------------- model ----------------
   int          cyc = 0;
   bit          busy    [N];
   int          acc_cyc [N];
   bit          m_write [N];
   bit          m_err   [N];
   int          m_idx   [N];
   logic [31:0] m_wdata [N];
   logic [31:0] m_rdata [N];
   int          n_acc   [N];
   logic [31:0] mem     [N][DEPTH];

   function automatic void decode(input logic [31:0] a, output bit err, output int idx);
`ifdef DMEM_RESPONDER_ERR_EN
      err = (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
      idx = err ? 0 : int'(a >> 2);
`else
      err = 1'b0;
      idx = int'((a >> 2) % DEPTH);
`endif
   endfunction

   initial begin
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < DEPTH; j++) mem[i][j] = 32'(j);
      end
   end

   // Access happens on edge acc+L-1 (the response cycle follows it); the
   // block is free again after edge acc+L.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            for (int i = 0; i < N; i++) begin
               if (!busy[i] && req_valid[i]) begin
                  busy[i]    = 1'b1;
                  acc_cyc[i] = cyc;
                  m_write[i] = req_write[i];
                  m_wdata[i] = req_wdata[i];
                  decode(req_addr[i], m_err[i], m_idx[i]);
                  n_acc[i]++;
               end else if (busy[i] && cyc == acc_cyc[i] + i + 1) begin
                  busy[i] = 1'b0;
               end
               if (busy[i] && cyc == acc_cyc[i] + i) begin
                  m_rdata[i] = (m_write[i] || m_err[i]) ? 32'd0 : mem[i][m_idx[i]];
                  if (m_write[i] && !m_err[i]) mem[i][m_idx[i]] = m_wdata[i];
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge rst);
         for (int i = 0; i < N; i++) busy[i] = 1'b0;
      end
   end

   // ---------------- per-cycle compare ----------------
   int          resp_cnt   [N];
   int          resp_cyc   [N];
   logic [31:0] last_rdata [N];
   logic        last_err   [N];
   int          dut_acc_q  [N][$];
   logic [31:0] rdata_log  [N][$];

   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            bit rsp;
            rsp = busy[i] && (cyc == acc_cyc[i] + i);
            chk($sformatf("ready%0d@%0d", i, cyc), req_ready[i], rst && !busy[i]);
            chk($sformatf("valid%0d@%0d", i, cyc), resp_valid[i], rst && rsp);
            chk($sformatf("stall%0d@%0d", i, cyc), stall[i],
                rst && (busy[i] ? !rsp : req_valid[i]));
            chk($sformatf("rdata%0d@%0d", i, cyc), resp_rdata[i], rsp ? m_rdata[i] : 32'd0);
            chk($sformatf("err%0d@%0d", i, cyc), resp_err[i], rsp && m_err[i]);
            if (resp_valid[i] === 1'b1) begin
               resp_cnt[i]++;
               resp_cyc[i]   = cyc;
               last_rdata[i] = resp_rdata[i];
               last_err[i]   = resp_err[i];
               rdata_log[i].push_back(resp_rdata[i]);
            end
            if (rst && req_valid[i] && req_ready[i] === 1'b1) dut_acc_q[i].push_back(cyc + 1);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input int i, input bit w, input logic [31:0] a, input logic [31:0] d);
      int tgt;
      int n;
      req_write[i] = w;
      req_addr[i]  = a;
      req_wdata[i] = d;
      req_valid[i] = 1'b1;
      tgt = n_acc[i] + 1;
      n   = 0;
      while (n_acc[i] < tgt && n < 40) begin
         @(posedge clk); #2;
         n++;
      end
      req_valid[i] = 1'b0;
      if (n_acc[i] < tgt) fail_now($sformatf("accept%0d", i));
   endtask

   task automatic wait_resp(input int i, input int target);
      int n;
      n = 0;
      while (resp_cnt[i] < target && n < 40) begin
         @(posedge clk); #2;
         n++;
      end
      if (resp_cnt[i] < target) fail_now($sformatf("resp%0d", i));
   endtask

   task automatic xact(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er);
      int rc0;
      rc0 = resp_cnt[i];
      send(i, w, a, d);
      wait_resp(i, rc0 + 1);
      rd = last_rdata[i];
      er = last_err[i];
   endtask

   task automatic burst(input int i, input int gap);
      int base_acc;
      int base_resp;
      int tgt;
      int n;
      base_acc  = dut_acc_q[i].size();
      base_resp = resp_cnt[i];
      rdata_log[i].delete();
      req_write[i] = 1'b0;
      req_valid[i] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         req_addr[i] = 32'(k * 4);
         tgt = n_acc[i] + 1;
         n   = 0;
         while (n_acc[i] < tgt && n < 40) begin
            @(posedge clk); #2;
            n++;
         end
         if (n_acc[i] < tgt) fail_now($sformatf("burst_acc%0d", i));
      end
      req_valid[i] = 1'b0;
      wait_resp(i, base_resp + 4);
      repeat (10) @(posedge clk);
      #2;
      chk($sformatf("burst_pulses%0d", i), resp_cnt[i] - base_resp, 4);
      chk($sformatf("burst_accepts%0d", i), dut_acc_q[i].size() - base_acc, 4);
      if (dut_acc_q[i].size() - base_acc >= 4) begin
         for (int k = 1; k < 4; k++) begin
            chk($sformatf("burst_gap%0d_%0d", i, k),
                dut_acc_q[i][base_acc + k] - dut_acc_q[i][base_acc + k - 1], gap);
         end
      end
      if (rdata_log[i].size() >= 4) begin
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("burst_data%0d_%0d", i, k), rdata_log[i][k], 32'(k));
         end
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          rc;
      for (int i = 0; i < N; i++) begin
         req_valid[i] = 1'b0;
         req_write[i] = 1'b0;
         req_addr[i]  = 32'd0;
         req_wdata[i] = 32'd0;
      end
      rst = 1'b1;
      #1 rst = 1'b0;
      req_valid[1] = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_ready", req_ready[1], 0);
      chk("rst_stall", stall[1], 0);
      chk("rst_valid", resp_valid[1], 0);
      req_valid[1] = 1'b0;
      rst = 1'b1;
      @(posedge clk); #2;
      chk("post_rst_ready", req_ready[1], 1);

      // load 0x10 on LATENCY=2
      xact(1, 1'b0, 32'h10, 32'd0, rd, er);
      chk("ld10_data", rd, 32'h4);
      chk("ld10_err", er, 0);
      chk("ld10_lat", resp_cyc[1] - dut_acc_q[1][$], 1);

      // store then load
      xact(1, 1'b1, 32'h20, 32'hDEADBEEF, rd, er);
      chk("st20_rdata", rd, 32'h0);
      xact(1, 1'b0, 32'h20, 32'd0, rd, er);
      chk("ld20_data", rd, 32'hDEADBEEF);

      // misaligned load
      xact(1, 1'b0, 32'h13, 32'd0, rd, er);
`ifdef DMEM_RESPONDER_ERR_EN
      chk("ld13_err", er, 1);
      chk("ld13_data", rd, 32'h0);
`else
      chk("ld13_err", er, 0);
      chk("ld13_data", rd, 32'h4);
`endif

      // out-of-range store, then load of word 0
      xact(1, 1'b1, 32'h200, 32'h1234, rd, er);
      chk("st200_rdata", rd, 32'h0);
      xact(1, 1'b0, 32'h0, 32'd0, rd, er);
`ifdef DMEM_RESPONDER_ERR_EN
      chk("ld0_data", rd, 32'h0);
      chk("model_pin_w0", mem[1][0], 32'h0);
`else
      chk("ld0_data", rd, 32'h1234);
      chk("model_pin_w0", mem[1][0], 32'h1234);
`endif

      // store aborted by reset during WAIT
      rc = resp_cnt[1];
      send(1, 1'b1, 32'h08, 32'h55);
      rst = 1'b0;
      #1;
      chk("abort_valid", resp_valid[1], 0);
      chk("abort_err", resp_err[1], 0);
      chk("abort_rdata", resp_rdata[1], 0);
      chk("abort_stall", stall[1], 0);
      chk("abort_ready", req_ready[1], 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk); #2;
      chk("abort_no_resp", resp_cnt[1] - rc, 0);
      xact(1, 1'b0, 32'h08, 32'd0, rd, er);
      chk("ld08_after_abort", rd, 32'h2);

      // back-to-back loads with req_valid held high
      burst(0, 2);
      burst(2, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule
